// File: rtl/cod_pkg.sv
// Shared parameters, state encoding and the N clamp for the Fibonacci register-file sequencer.
package cod_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEED0,
    SEED1,
    RD,
    EX,
    WB,
    DONE
  } state_t;

  // Runs need at least the two seeds and cannot exceed the file.
  function automatic logic [5:0] clamp_n(input logic [5:0] n);
    if (n < 6'd2) begin
      return 6'd2;
    end else if (n > 6'(DEPTH)) begin
      return 6'(DEPTH);
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/fib_seq_ctrl.sv
// Drives a registered-read register file to build a Fibonacci table: two seed writes,
// then RD/EX/WB per term (3N-3 cycles start to done). start is ignored while busy.
module fib_seq_ctrl
  import cod_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  input  logic [5:0]        n_terms,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r1_dout,
  input  logic [DATA_W-1:0] r2_dout,
  output logic [ADDR_W-1:0] r3_addr,
  output logic [DATA_W-1:0] r3_din,
  output logic              r3_wr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] last_term,
  output logic              overflow
);

  state_t              r_state;
  logic [5:0]          r_i;
  logic [5:0]          r_n;
  logic [DATA_W-1:0]   r_seed1;

  state_t              w_state;
  logic [5:0]          w_i;
  logic [5:0]          w_n;
  logic [5:0]          w_i_inc;
  logic [DATA_W-1:0]   w_seed1;
  logic [ADDR_W-1:0]   w_r1_addr;
  logic [ADDR_W-1:0]   w_r2_addr;
  logic [ADDR_W-1:0]   w_r3_addr;
  logic [DATA_W-1:0]   w_r3_din;
  logic                w_r3_wr;
  logic [DATA_W-1:0]   w_last;
  logic                w_ovf;
  logic [DATA_W:0]     w_sum;

  assign w_sum   = {1'b0, r1_dout} + {1'b0, r2_dout};
  assign w_i_inc = r_i + 6'd1;

  // Next-state logic also computes the outputs of the state being entered, so every
  // output is a flop that is stable for the whole cycle of its state.
  always_comb begin
    w_state   = r_state;
    w_i       = r_i;
    w_n       = r_n;
    w_seed1   = r_seed1;
    w_r1_addr = r1_addr;
    w_r2_addr = r2_addr;
    w_r3_addr = r3_addr;
    w_r3_din  = r3_din;
    w_r3_wr   = 1'b0;
    w_last    = last_term;
    w_ovf     = overflow;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state   = SEED0;
          w_seed1   = seed1;
          w_n       = clamp_n(n_terms);
          w_i       = 6'd2;
          w_ovf     = 1'b0;
          w_r3_wr   = 1'b1;
          w_r3_addr = '0;
          w_r3_din  = seed0;
          w_last    = seed0;
        end
      end
      SEED0: begin
        w_state   = SEED1;
        w_r3_wr   = 1'b1;
        w_r3_addr = ADDR_W'(1);
        w_r3_din  = r_seed1;
        w_last    = r_seed1;
      end
      SEED1: begin
        if (r_n > 6'd2) begin
          w_state   = RD;
          w_r1_addr = r_i - 6'd2;
          w_r2_addr = r_i - 6'd1;
        end else begin
          w_state = DONE;
        end
      end
      RD: begin
        w_state = EX;
      end
      EX: begin
        // Read data for the addresses presented in RD is valid here.
        w_state   = WB;
        w_ovf     = overflow | w_sum[DATA_W];
        w_r3_wr   = 1'b1;
        w_r3_addr = r_i;
        w_r3_din  = w_sum[DATA_W-1:0];
        w_last    = w_sum[DATA_W-1:0];
      end
      WB: begin
        w_i = w_i_inc;
        if (w_i_inc == r_n) begin
          w_state = DONE;
        end else begin
          w_state   = RD;
          w_r1_addr = r_i - 6'd1;
          w_r2_addr = r_i;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_n       <= '0;
      r_seed1   <= '0;
      r1_addr   <= '0;
      r2_addr   <= '0;
      r3_addr   <= '0;
      r3_din    <= '0;
      r3_wr     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      last_term <= '0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_i       <= w_i;
      r_n       <= w_n;
      r_seed1   <= w_seed1;
      r1_addr   <= w_r1_addr;
      r2_addr   <= w_r2_addr;
      r3_addr   <= w_r3_addr;
      r3_din    <= w_r3_din;
      r3_wr     <= w_r3_wr;
      busy      <= (w_state != IDLE);
      done      <= (w_state == DONE);
      last_term <= w_last;
      overflow  <= w_ovf;
    end
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Sequencer plus a registered-read register file, checked every cycle against a
// cycle-indexed Fibonacci model and against hand-computed table contents.
module tb_fib_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed0 = '0;
  logic [31:0] seed1 = '0;
  logic [5:0]  n_terms = '0;
  logic [5:0]  r1_addr, r2_addr, r3_addr;
  logic [31:0] r1_dout, r2_dout, r3_din, last_term;
  logic        r3_wr, busy, done, overflow;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  fib_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed0(seed0), .seed1(seed1),
    .n_terms(n_terms), .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_dout(r1_dout),
    .r2_dout(r2_dout), .r3_addr(r3_addr), .r3_din(r3_din), .r3_wr(r3_wr),
    .busy(busy), .done(done), .last_term(last_term), .overflow(overflow)
  );

  // Register file: synchronous write, registered read; reset clears the addressed entry.
  logic [31:0] rf_mem [0:63];
  always @(posedge clk) begin
    if (!rst_n) rf_mem[r3_addr] <= '0;
    else if (r3_wr) rf_mem[r3_addr] <= r3_din;
    r1_dout <= rf_mem[r1_addr];
    r2_dout <= rf_mem[r2_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one run is a table f[0..n-1] plus per-term carries; outputs are a
  // function of the cycle index k counted from the start-sampling edge.
  bit          m_act = 0;
  bit          m_rst_seen = 1;
  int          m_k = 0;
  int          m_n = 2;
  logic [31:0] m_f [0:31];
  bit          m_c [0:31];
  logic [31:0] m_last = '0;
  bit          m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_k = 0; m_last = '0; m_ovf = 0; m_rst_seen = 1;
    end else if (m_act) begin
      m_k = m_k + 1;
      if (m_k > 3 * m_n - 3) begin
        m_act  = 0;
        m_last = m_f[m_n-1];
        m_ovf  = 0;
        for (int j = 2; j < m_n; j++) if (m_c[j]) m_ovf = 1;
      end
    end else if (start) begin
      logic [32:0] s;
      m_n = (n_terms < 2) ? 2 : (n_terms > 32) ? 32 : int'(n_terms);
      m_f[0] = seed0; m_f[1] = seed1; m_c[0] = 0; m_c[1] = 0;
      for (int j = 2; j < m_n; j++) begin
        s = {1'b0, m_f[j-1]} + {1'b0, m_f[j-2]};
        m_f[j] = s[31:0];
        m_c[j] = s[32];
      end
      m_k = 1; m_act = 1; m_rst_seen = 0;
    end
  end

  int          e_w;
  bit          e_wr, e_ovf;
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (chk_en) begin
      if (!m_act) begin
        chk("busy", busy, 0);
        chk("done", done, 0);
        chk("r3_wr", r3_wr, 0);
        chk("last_term", last_term, m_last);
        chk("overflow", overflow, m_ovf);
        if (m_rst_seen) begin
          chk("rst_r1_addr", r1_addr, 0);
          chk("rst_r2_addr", r2_addr, 0);
          chk("rst_r3_addr", r3_addr, 0);
          chk("rst_r3_din", r3_din, 0);
        end
      end else begin
        e_w  = (m_k == 1) ? 0 : (m_k < 5) ? 1 : (m_k + 1) / 3;
        e_wr = (m_k == 1) || (m_k == 2) || (m_k >= 5 && (m_k + 1) % 3 == 0);
        e_ovf = 0;
        for (int j = 2; j < m_n; j++) if (m_c[j] && 3 * j - 1 <= m_k) e_ovf = 1;
        chk("busy", busy, 1);
        chk("done", done, (m_k == 3 * m_n - 3));
        chk("r3_wr", r3_wr, e_wr);
        chk("last_term", last_term, m_f[e_w]);
        chk("overflow", overflow, e_ovf);
        if (e_wr) begin
          chk("r3_addr", r3_addr, e_w);
          chk("r3_din", r3_din, m_f[e_w]);
        end
        if (m_k >= 3 && m_k % 3 == 0 && m_k <= 3 * m_n - 6) begin
          chk("r1_addr", r1_addr, m_k / 3 - 1);
          chk("r2_addr", r2_addr, m_k / 3);
        end
      end
    end
  end

  // Returns cycles from the start-sampling edge to done (-1 if aborted by reset).
  task automatic run_fib(input logic [31:0] s0, input logic [31:0] s1, input logic [5:0] n,
                         input int pulse_at, input int rst_at, output int cyc);
    int d0;
    d0 = done_seen;
    @(posedge clk); #1;
    seed0 = s0; seed1 = s1; n_terms = n; start = 1;
    @(posedge clk); #1;
    start = 0; seed0 = $urandom; seed1 = $urandom; n_terms = 6'($urandom);
    cyc = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc >= 200) begin
        total++; bad++;
        $display("FAIL timeout: no done after %0d cycles", cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == rst_at) begin
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done_cnt", done_seen - d0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc = -1;
        break;
      end
    end
    if (cyc >= 0) begin
      @(posedge clk); #1;
      chk("done_pulses", done_seen - d0, 1);
      chk("busy_after", busy, 0);
    end
  endtask

  int cyc;
  logic [31:0] fib10 [0:9];

  initial begin
    fib10 = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34, 32'd55};
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1;

    // N above DEPTH clamps to 32
    run_fib(32'd1, 32'd1, 6'd40, 0, 0, cyc);
    chk("s3_cycles", cyc, 93);
    chk("s3_mem31", rf_mem[31], 32'd2178309);
    chk("s3_mem10", rf_mem[10], 32'd89);

    // basic N=10; entry 10 must keep the value from the previous run
    run_fib(32'd1, 32'd1, 6'd10, 0, 0, cyc);
    chk("s1_cycles", cyc, 27);
    for (int i = 0; i < 10; i++) chk($sformatf("s1_mem%0d", i), rf_mem[i], fib10[i]);
    chk("s1_mem10_untouched", rf_mem[10], 32'd89);
    chk("s1_last", last_term, 32'd55);
    chk("s1_ovf", overflow, 0);

    // N=0 and N=1 behave as N=2
    for (int n = 0; n < 2; n++) begin
      run_fib(32'd7, 32'd9, 6'(n), 0, 0, cyc);
      chk($sformatf("s2_n%0d_cycles", n), cyc, 3);
      chk($sformatf("s2_n%0d_mem0", n), rf_mem[0], 32'd7);
      chk($sformatf("s2_n%0d_mem1", n), rf_mem[1], 32'd9);
      chk($sformatf("s2_n%0d_mem2", n), rf_mem[2], 32'd2);
      chk($sformatf("s2_n%0d_last", n), last_term, 32'd9);
    end

    // carry out sets overflow; next run clears it
    run_fib(32'h8000_0000, 32'h8000_0000, 6'd3, 0, 0, cyc);
    chk("s4_mem2", rf_mem[2], 32'd0);
    chk("s4_ovf", overflow, 1);
    chk("s4_cycles", cyc, 6);
    run_fib(32'd1, 32'd1, 6'd3, 0, 0, cyc);
    chk("s4b_ovf", overflow, 0);
    chk("s4b_mem2", rf_mem[2], 32'd2);

    // start pulse mid-run ignored
    run_fib(32'd1, 32'd1, 6'd10, 5, 0, cyc);
    chk("s5_cycles", cyc, 27);
    chk("s5_mem9", rf_mem[9], 32'd55);
    chk("s5_last", last_term, 32'd55);

    // reset mid-run, then a clean rerun
    run_fib(32'd1, 32'd1, 6'd10, 0, 10, cyc);
    chk("s6_aborted", cyc, -1);
    chk("s6_last_cleared", last_term, 0);
    run_fib(32'd1, 32'd1, 6'd10, 0, 0, cyc);
    chk("s6_cycles", cyc, 27);
    for (int i = 0; i < 10; i++) chk($sformatf("s6_mem%0d", i), rf_mem[i], fib10[i]);
    chk("s6_last", last_term, 32'd55);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
